uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit path (the transceiver's send_req/send_data/txq_full interface) between N_REQ byte-stream requesters, e.g. CPU console, trace unit and boot monitor.
- Arbitration is round-robin and message-atomic: the grant stays locked to one requester until it sends a byte flagged last, so messages never interleave.
- A stall timeout revokes the grant from an owner that stops supplying bytes mid-message.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- TIMEOUT, 1024, consecutive owner-stall cycles before forced release; 0 disables the timeout.

Ports:
- clk  input  1  system clock.
- rstn  input  1  reset, asynchronous, active-low.
- req_valid  input  N_REQ  per-requester byte valid.
- req_data  input  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  input  N_REQ  per-requester flag marking the final byte of a message.
- req_ready  output  N_REQ  per-requester accept; combinational.
- send_req  output  1  write strobe to the transceiver TX FIFO; combinational.
- send_data  output  8  byte to the transceiver TX FIFO; combinational.
- txq_full  input  1  transceiver TX FIFO full.
- busy  output  1  high while a grant is locked.
- grant_id  output  3  index of the current owner; holds the last owner value when idle.
- timeout_pulse  output  1  1-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset: all of the following take effect asynchronously.
  - state=IDLE; busy=0, grant_id=0, timeout_pulse=0.
  - last_owner=N_REQ-1, so requester 0 has first priority after reset.
  - Stall counter=0.
  - Combinational outputs req_ready, send_req and send_data are 0 while in IDLE.
- State IDLE:
  - If any req_valid bit is set, pick the first set index scanning last_owner+1, last_owner+2, ... modulo N_REQ.
  - Next cycle: state=LOCK, owner=picked index, busy=1, grant_id=owner.
  - Arbitration latency is 1 cycle; no byte is transferred in the IDLE cycle.
- State LOCK:
  - req_ready[owner]=~txq_full; all other req_ready bits are 0.
  - A transfer occurs when req_valid[owner] & req_ready[owner]. In that same cycle, send_req=1 and send_data=req_data[owner].
  - send_req is never asserted while txq_full=1. Each accepted byte produces exactly one send_req cycle, with no loss or duplication.
  - Transfer with req_last[owner]=1: next state IDLE, last_owner=owner, busy=0.
  - After a message ends there is always at least one IDLE cycle before the next grant.
  - Owner deasserts valid without last: the lock is held and no other requester is served.
- Stall timeout (only when TIMEOUT>0):
  - Counter width is clog2(TIMEOUT+1).
  - In LOCK, the counter increments each cycle in which req_valid[owner]=0 and clears on any cycle in which req_valid[owner]=1.
  - Cycles with txq_full=1 and valid=1 are not stalls.
  - When the counter reaches TIMEOUT: next state IDLE, last_owner=owner, timeout_pulse=1 for one cycle, counter cleared.
  - The partial message stays in the TX FIFO; no recovery framing is inserted.
- Simultaneous events:
  - A last-byte transfer in the same cycle as the counter reaching TIMEOUT counts as a normal completion: no timeout_pulse.
  - Requests arriving during LOCK wait; they are not queued or latched, and are re-evaluated in IDLE.
- Reset mid-message: returns to IDLE immediately and drops the lock. Bytes already written to the TX FIFO are not this block's concern.
- Requester inputs are sampled only through the owner index; non-owner inputs have no effect in LOCK.

Test Plan:
- Single owner, sequential bytes: req0 sends 0x41, 0x42, 0x43 back-to-back with last on 0x43, txq_full=0 -> grant_id=0 and busy=1 one cycle after valid; send_req high 3 consecutive cycles with data 41, 42, 43; busy=0 the cycle after 0x43.
- Round-robin and atomicity: reqs 0, 1, 2 each continuously offer 2-byte messages (0xA0/0xA1, 0xB0/0xB1, 0xC0/0xC1) -> output byte sequence A0 A1 B0 B1 C0 C1 A0 ...; never interleaved; 1 IDLE cycle between messages.
- Backpressure: txq_full held high for 5 cycles mid-message -> req_ready[owner]=0 and send_req=0 for those 5 cycles; the remaining bytes follow in order with none lost or duplicated.
- Stall timeout: TIMEOUT=16; req0 sends 1 byte without last, then drops valid while req1 is valid -> timeout_pulse exactly 16 cycles after the drop; req1 granted; req0 is not re-granted before req1 finishes. Separately, with TIMEOUT=0 the same stimulus holds the lock indefinitely.
- Priority rotation: last owner was 1; req0 and req2 become valid together -> req2 granted first, then req0.
- Async reset: assert rstn=0 mid-message, asynchronous to clk -> busy, send_req and req_ready drop to 0 immediately. After release with reqs 1 and 2 valid -> req1 granted first (rotation start reset to requester 0).

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, message-atomic sharing of one UART TX FIFO among N_REQ byte streams
module uart_tx_arbiter #(
    parameter int N_REQ   = 3,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic               send_req,
    output logic [7:0]         send_data,
    input  logic               txq_full,
    output logic               busy,
    output logic [2:0]         grant_id,
    output logic               timeout_pulse
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    typedef enum logic {IDLE, LOCK} state_t;
    state_t        state_q, state_d;
    logic [2:0]    owner_q, owner_d, last_q, last_d, pick;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          tp_q, tp_d;
    logic          lock, own_valid, own_last, stall, done, expire, found;
    logic [7:0]    own_data;
    assign lock = state_q == LOCK;
    // owner mux plus rotating scan starting just after the previous owner
    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = 8'h00;
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner_q == 3'(i)) begin
                own_valid    = req_valid[i];
                own_last     = req_last[i];
                own_data     = req_data[8*i +: 8];
                req_ready[i] = lock & ~txq_full;
            end
        end
        pick  = last_q;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!found && req_valid[i] && i == (int'(last_q) + k) % N_REQ) begin
                    pick  = 3'(i);
                    found = 1'b1;
                end
            end
        end
    end
    assign send_req  = lock & own_valid & ~txq_full;
    assign send_data = send_req ? own_data : 8'h00;
    assign done      = send_req & own_last;
    assign stall     = lock & ~own_valid;
    assign cnt_inc   = cnt_q + 1'b1;
    assign expire    = (TIMEOUT > 0) && stall && (cnt_inc == CW'(TIMEOUT));
    always_comb begin
        state_d = !lock ? (found ? LOCK : IDLE) : (done || expire) ? IDLE : LOCK;
        owner_d = (!lock && found) ? pick : owner_q;
        last_d  = (lock && (done || expire)) ? owner_q : last_q;
        cnt_d   = ((TIMEOUT > 0) && stall && !expire) ? cnt_inc : '0;
        tp_d    = expire;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            owner_q <= 3'd0;
            last_q  <= 3'(N_REQ - 1);
            cnt_q   <= '0;
            tp_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            tp_q    <= tp_d;
        end
    end
    assign busy          = lock;
    assign grant_id      = owner_q;
    assign timeout_pulse = tp_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed plus randomized checks of two arbiters (stall timeout 16 and disabled)
module tb_uart_tx_arbiter;
    localparam int N  = 3;
    localparam int TO = 16;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;
    logic [N-1:0]   req_valid, req_last, a_ready, b_ready;
    logic [8*N-1:0] req_data;
    logic           txq_full, a_send, b_send, a_busy, b_busy, a_tp, b_tp;
    logic [7:0]     a_data, b_data;
    logic [2:0]     a_gid, b_gid;
    uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(a_ready), .send_req(a_send), .send_data(a_data), .txq_full(txq_full),
        .busy(a_busy), .grant_id(a_gid), .timeout_pulse(a_tp));
    uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(0)) dut_noto (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(b_ready), .send_req(b_send), .send_data(b_data), .txq_full(txq_full),
        .busy(b_busy), .grant_id(b_gid), .timeout_pulse(b_tp));
    int n_tests = 0;
    int n_fail  = 0;
    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // reference model, one per DUT: [0] timeout 16, [1] timeout disabled
    bit m_busy[2];
    bit m_tp[2];
    int m_owner[2], m_last[2], m_stall[2], m_to[2];
    // requester sources: per-requester circular byte queues {last, data}
    logic [8:0] mem[N][256];
    logic [7:0] hd[N], tl[N];
    logic [N-1:0] en;
    int pv;
    bit rnd_full, full;
    logic [7:0] lg[$];
    logic s_send, s_tp;
    logic [N-1:0] s_ready;
    function automatic bit xfer(int m);
        return m_busy[m] && req_valid[m_owner[m]] && !txq_full;
    endfunction
    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_busy[m]  = 0;
            m_tp[m]    = 0;
            m_owner[m] = 0;
            m_last[m]  = N - 1;
            m_stall[m] = 0;
        end
    endtask
    task automatic model_upd(int m);
        bit x;
        int o;
        bit got;
        x = xfer(m);
        o = m_owner[m];
        got = 0;
        m_tp[m] = 0;
        if (!m_busy[m]) begin
            for (int k = 1; k <= N; k++) begin
                if (!got && req_valid[(m_last[m] + k) % N]) begin
                    got = 1;
                    m_owner[m] = (m_last[m] + k) % N;
                    m_busy[m] = 1;
                    m_stall[m] = 0;
                end
            end
        end else if (x && req_last[o]) begin
            m_busy[m] = 0;
            m_last[m] = o;
            m_stall[m] = 0;
        end else if (!req_valid[o]) begin
            m_stall[m]++;
            if (m_to[m] > 0 && m_stall[m] == m_to[m]) begin
                m_busy[m] = 0;
                m_last[m] = o;
                m_tp[m] = 1;
                m_stall[m] = 0;
            end
        end else begin
            m_stall[m] = 0;
        end
    endtask
    task automatic check(int m);
        logic [N-1:0] r;
        bit x;
        r = '0;
        if (m_busy[m] && !txq_full) r[m_owner[m]] = 1'b1;
        x = xfer(m);
        chk(m ? "b_busy"  : "a_busy",  m ? b_busy  : a_busy,  m_busy[m]);
        chk(m ? "b_gid"   : "a_gid",   m ? b_gid   : a_gid,   m_owner[m]);
        chk(m ? "b_tp"    : "a_tp",    m ? b_tp    : a_tp,    m_tp[m]);
        chk(m ? "b_ready" : "a_ready", m ? b_ready : a_ready, r);
        chk(m ? "b_send"  : "a_send",  m ? b_send  : a_send,  x);
        if (x) chk(m ? "b_data" : "a_data", m ? b_data : a_data, req_data[8*m_owner[m] +: 8]);
        else if (!m_busy[m]) chk(m ? "b_data_idle" : "a_data_idle", m ? b_data : a_data, 0);
    endtask
    task automatic push(int i, logic [7:0] d, bit last);
        mem[i][tl[i]] = {last, d};
        tl[i] = tl[i] + 8'd1;
    endtask
    task automatic drive();
        for (int i = 0; i < N; i++) begin
            logic [8:0] h;
            h = mem[i][hd[i]];
            req_valid[i] = en[i] && (hd[i] != tl[i]) && ($urandom_range(99) < pv);
            req_last[i] = h[8];
            req_data[8*i +: 8] = h[7:0];
        end
        txq_full = rnd_full ? ($urandom_range(99) < 25) : full;
    endtask
    task automatic step();
        drive();
        @(negedge clk);
        check(0);
        check(1);
        s_send = a_send;
        s_ready = a_ready;
        s_tp = a_tp;
        if (a_send) lg.push_back(a_data);
        if (xfer(0)) hd[m_owner[0]] = hd[m_owner[0]] + 8'd1;
        @(posedge clk);
        model_upd(0);
        model_upd(1);
        #1;
    endtask
    task automatic do_reset();
        rstn = 1'b0;
        en = '0;
        rnd_full = 0;
        full = 0;
        pv = 100;
        for (int i = 0; i < N; i++) begin
            hd[i] = 8'd0;
            tl[i] = 8'd0;
        end
        req_valid = '0;
        req_last = '0;
        req_data = '0;
        txq_full = 1'b0;
        model_reset();
        lg.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask
    task automatic chk_log(string tag, int n, logic [95:0] exp);
        chk({tag, "_len"}, lg.size(), n);
        for (int i = 0; i < n; i++)
            if (i < lg.size()) chk(tag, lg[i], exp[8*(n-1-i) +: 8]);
        lg.delete();
    endtask
    int found_at;
    int pvs[3];
    initial begin
        m_to[0] = TO;
        m_to[1] = 0;
        pvs[0] = 95;
        pvs[1] = 60;
        pvs[2] = 10;
        do_reset();
        chk("rst_busy", a_busy, 0);
        chk("rst_gid", a_gid, 0);
        chk("rst_tp", a_tp, 0);
        chk("rst_ready", a_ready, 0);
        chk("rst_send", a_send, 0);
        // single owner, three back-to-back bytes
        push(0, 8'h41, 0);
        push(0, 8'h42, 0);
        push(0, 8'h43, 1);
        en = 3'b001;
        step();
        chk("t1_busy", a_busy, 1);
        chk("t1_gid", a_gid, 0);
        chk("t1_idle_send", s_send, 0);
        repeat (5) step();
        chk("t1_end_busy", a_busy, 0);
        chk_log("t1_bytes", 3, 96'h414243);
        // round robin with 2-byte messages on all requesters
        do_reset();
        for (int r = 0; r < 2; r++) begin
            push(0, 8'hA0, 0); push(0, 8'hA1, 1);
            push(1, 8'hB0, 0); push(1, 8'hB1, 1);
            push(2, 8'hC0, 0); push(2, 8'hC1, 1);
        end
        en = '1;
        repeat (22) step();
        chk_log("t2_rr", 12, 96'hA0A1B0B1C0C1A0A1B0B1C0C1);
        // backpressure mid-message
        do_reset();
        push(0, 8'h10, 0); push(0, 8'h11, 0); push(0, 8'h12, 0); push(0, 8'h13, 1);
        en = 3'b001;
        repeat (2) step();
        full = 1;
        for (int j = 0; j < 5; j++) begin
            step();
            chk("t3_full_send", s_send, 0);
            chk("t3_full_ready", s_ready, 0);
        end
        full = 0;
        repeat (6) step();
        chk_log("t3_bytes", 4, 96'h10111213);
        // owner stalls mid-message while requester 1 waits
        do_reset();
        push(0, 8'h55, 0);
        push(1, 8'h66, 0); push(1, 8'h67, 1);
        en = 3'b011;
        repeat (2) step();
        found_at = -1;
        for (int j = 1; j <= 40 && found_at < 0; j++) begin
            step();
            if (s_tp) found_at = j;
        end
        chk("t4_to_delay", found_at - 1, TO);
        chk("t4_noto_busy", b_busy, 1);
        chk("t4_noto_gid", b_gid, 0);
        push(0, 8'h56, 1);
        repeat (10) step();
        chk_log("t4_bytes", 4, 96'h55666756);
        // rotation resumes after last owner 1
        do_reset();
        push(1, 8'h11, 1);
        en = '1;
        repeat (3) step();
        push(0, 8'hA5, 1);
        push(2, 8'hC5, 1);
        repeat (8) step();
        chk_log("t5_rot", 3, 96'h11C5A5);
        // asynchronous reset mid-message
        do_reset();
        for (int j = 1; j <= 5; j++) push(0, 8'(j), j == 5);
        en = 3'b001;
        repeat (3) step();
        drive();
        #2;
        chk("t6_pre_send", a_send, 1);
        chk("t6_pre_busy", a_busy, 1);
        rstn = 1'b0;
        #1;
        chk("t6_busy", a_busy, 0);
        chk("t6_send", a_send, 0);
        chk("t6_ready", a_ready, 0);
        chk("t6_noto_busy", b_busy, 0);
        do_reset();
        push(1, 8'h21, 1);
        push(2, 8'h31, 1);
        en = '1;
        repeat (8) step();
        chk_log("t6_after", 2, 96'h2131);
        // randomized traffic with random backpressure and stalls
        do_reset();
        en = '1;
        rnd_full = 1;
        for (int ph = 0; ph < 3; ph++) begin
            pv = pvs[ph];
            for (int c = 0; c < 1000; c++) begin
                for (int i = 0; i < N; i++) begin
                    if (8'(tl[i] - hd[i]) < 8'd8 && $urandom_range(3) == 0) begin
                        int len;
                        len = $urandom_range(4, 1);
                        for (int j = 0; j < len; j++) push(i, 8'($urandom), j == len - 1);
                    end
                end
                step();
            end
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
